// File: rtl/instr_fetch_queue.sv
// Purpose: in-order circular FIFO of (pc, instr) pairs between fetch and decode, discarded on PC redirect.
// Latency: a pushed pair is visible at the head one cycle after its push edge; there is no bypass.
// Backpressure: in_ready drops at full, fetch_stall rises one slot early; both are derived from registered count only.
module instr_fetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [PC_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]    in_instr,
  output logic                     in_ready,
  output logic                     fetch_stall,
  output logic                     out_valid,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - 1);

  logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // Handshake and status decode; flush masks both sides so a redirect cycle moves nothing.
  always_comb begin
    in_ready    = (count != FULL_CNT);
    fetch_stall = (count >= ALMOST_CNT);
    out_valid   = (count != '0) && !flush;
    out_pc      = pc_mem[rd_ptr];
    out_instr   = instr_mem[rd_ptr];
    push        = in_valid && in_ready && !flush;
    pop         = out_valid && out_ready;
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage; cleared on reset, left stale (but unreachable) on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios with literal expectations plus
// a queue-based reference model compared against the outputs every cycle.
module tb_instr_fetch_queue;

  localparam int PCW = 32;
  localparam int DW  = 32;
  localparam int D   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic [PCW-1:0]  in_pc;
  logic [DW-1:0]   in_instr;
  logic            in_ready;
  logic            fetch_stall;
  logic            out_valid;
  logic [PCW-1:0]  out_pc;
  logic [DW-1:0]   out_instr;
  logic            out_ready;
  logic [2:0]      count;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_on = 1'b0;

  // Reference model: a plain queue of {pc, instr}.
  logic [PCW+DW-1:0] q[$];

  instr_fetch_queue #(.PC_WIDTH(PCW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .fetch_stall(fetch_stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge from the inputs as sampled there.
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (q.size() != 0) && out_ready;
      do_push = in_valid && (q.size() != D);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({in_pc, in_instr});
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      bit exp_vld;
      exp_vld = (q.size() != 0) && !flush;
      check("m_count", 64'(count), 64'(q.size()));
      check("m_in_ready", 64'(in_ready), 64'(q.size() != D));
      check("m_stall", 64'(fetch_stall), 64'(q.size() >= D - 1));
      check("m_out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld) begin
        check("m_out_pc", 64'(out_pc), 64'(q[0][PCW+DW-1:DW]));
        check("m_out_instr", 64'(out_instr), 64'(q[0][DW-1:0]));
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_stall"}, 64'(fetch_stall), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  task automatic drain();
    int k;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    k = 0;
    while (count != 0 && k < 10) begin
      go();
      k++;
    end
    check("drain_done", 64'(count), 64'd0);
  endtask

  task automatic first_push(input string tag);
    drive(1'b1, 32'hBFC00000, 32'h00000013, 1'b0, 1'b0);
    check({tag, "_push_cycle_vld"}, 64'(out_valid), 64'd0);
    go();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check({tag, "_vis_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_vis_pc"}, 64'(out_pc), 64'hBFC00000);
    check({tag, "_vis_instr"}, 64'(out_instr), 64'h00000013);
    check({tag, "_vis_count"}, 64'(count), 64'd1);
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    go(); go();
    rst = 1'b0;
    #1;
    check_reset_vals("reset");
    model_on = 1'b1;

    // First push, one-cycle visibility, no bypass.
    first_push("s1");
    drain();

    // Fill to full; stall at 3, not ready at 4, fifth pair ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hBFC00000 + 32'(4 * i), 32'h00100093 + 32'(i), 1'b0, 1'b0);
      go();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_stall", 64'(fetch_stall), 64'(i >= 2));
      check("fill_ready", 64'(in_ready), 64'(i != 3));
    end
    drive(1'b1, 32'hBFC00010, 32'hDEADBEEF, 1'b0, 1'b0);
    go();
    check("full_ignore_count", 64'(count), 64'd4);
    check("full_head_pc", 64'(out_pc), 64'hBFC00000);

    // Full with push+pop requested: first cycle only pops.
    drive(1'b1, 32'hBFC00010, 32'h00200113, 1'b1, 1'b0);
    go();
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_head", 64'(out_pc), 64'hBFC00004);
    drive(1'b1, 32'hBFC00014, 32'h00300193, 1'b1, 1'b0);
    go();
    check("pushpop_count", 64'(count), 64'd3);
    check("pushpop_head", 64'(out_pc), 64'hBFC00008);
    drain();

    // Stream 10 pairs through the wrap, each visible one cycle after its push.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h00001000 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b1, 1'b0);
      go();
      check("stream_vld", 64'(out_valid), 64'd1);
      check("stream_pc", 64'(out_pc), 64'h00001000 + 64'(4 * i));
      check("stream_count", 64'(count), 64'd1);
    end
    drain();

    // Flush at count 3 with push and pop requested.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00000100 + 32'(4 * i), 32'h0, 1'b0, 1'b0);
      go();
    end
    check("preflush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h0000010C, 32'h11111111, 1'b1, 1'b1);
    check("flush_cycle_vld", 64'(out_valid), 64'd0);
    go();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("postflush_count", 64'(count), 64'd0);
    check("postflush_vld", 64'(out_valid), 64'd0);
    check("postflush_stall", 64'(fetch_stall), 64'd0);
    check("postflush_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h00002000, 32'h22222222, 1'b0, 1'b0);
    go();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("redirect_pc", 64'(out_pc), 64'h00002000);

    // Mid-stream reset at count 2.
    drive(1'b1, 32'h00002004, 32'h33333333, 1'b0, 1'b0);
    go();
    check("prerst_count", 64'(count), 64'd2);
    rst = 1'b1;
    drive(1'b1, 32'h00002008, 32'h44444444, 1'b1, 1'b1);
    go();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_reset_vals("midrst");
    first_push("s6");

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'h00004000 + 32'(4 * i), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      go();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    go();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Buffers instruction fetch results between the program counter/instruction memory path and the decode stage. Each cycle it accepts one (PC, instruction) pair, stores it in a small circular FIFO, and presents the pairs in order to decode with a valid/ready handshake. It drives a stall back to the PC counter when nearly full. It discards all buffered and incoming entries when a taken branch, jal or jalr redirects the PC.

## Interface
Parameters:
- PC_WIDTH, 32, width of the program counter
- DATA_WIDTH, 32, width of an instruction word
- DEPTH, 4, number of FIFO entries; power of two, at least 2

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  PC redirect this cycle; discards queue contents and any incoming pair
- in_valid  input  1  in_pc/in_instr hold a fetched pair
- in_pc  input  PC_WIDTH  address of the fetched instruction
- in_instr  input  DATA_WIDTH  fetched instruction word
- in_ready  output  1  queue can accept a pair this cycle
- fetch_stall  output  1  PC counter must hold its value (queue nearly full)
- out_valid  output  1  out_pc/out_instr hold the oldest buffered pair
- out_pc  output  PC_WIDTH  PC of the oldest entry
- out_instr  output  DATA_WIDTH  instruction of the oldest entry
- out_ready  input  1  decode consumes the head entry this cycle
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH

## Operation
- State: storage array of DEPTH {pc, instr} entries; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits; occupancy register count.
- push = in_valid && in_ready && !flush. On push, write the pair at wr_ptr and increment wr_ptr modulo DEPTH.
- pop = out_valid && out_ready. On pop, increment rd_ptr modulo DEPTH.
- count next value: count+1 on push only, count-1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH). When the queue is full, no push is accepted, even if a pop happens in the same cycle.
- out_valid = (count != 0) && !flush. out_pc/out_instr are read combinationally from storage[rd_ptr].
- fetch_stall = (count >= DEPTH-1). This leaves one slot of headroom for the pair already in flight from instruction memory.
- Flush has priority over push and pop. At the next edge, wr_ptr, rd_ptr and count all become 0. Storage contents are left unchanged but are unreachable. Because out_valid is forced low during flush, no pop occurs in a flush cycle.
- Reset has priority over everything else. It clears pointers, count and every storage entry to 0.
- Pointer wrap: after an index of DEPTH-1 the next index is 0. Ordering across the wrap must be preserved.

## Timing
- Reset values: in_ready=1, fetch_stall=0, out_valid=0, out_pc=0, out_instr=0, count=0.
- Push-to-visible latency is 1 cycle. A pair pushed at edge N drives out_valid=1 after edge N. There is no same-cycle bypass when the queue is empty.
- Pop takes effect at the edge. The next entry appears after that edge if count was at least 2 before the pop.
- Push and pop in the same cycle with 1 ≤ count ≤ DEPTH-1: count is unchanged and both pointers advance.
- After a flush edge, the queue is empty. The next cycle may push a pair from the redirected PC, which becomes visible one cycle later.
- Reset asserted mid-stream: all outputs take their reset values after that edge, regardless of in_valid, out_ready or flush.
- fetch_stall and in_ready depend only on count, which is registered. They therefore carry no combinational path from in_valid or out_ready.

## Test plan
- Reset, then in_valid=1 with in_pc=0xBFC00000, in_instr=0x00000013 and out_ready=0 for one cycle. Required: out_valid=1 with out_pc=0xBFC00000 and count=1 on the next cycle; out_valid=0 in the push cycle itself.
- Push 4 pairs at PCs 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C with out_ready=0. Required: fetch_stall=1 once count=3; in_ready=0 at count=4; a 5th in_valid is ignored and count stays 4.
- With the queue full, assert out_ready=1 and in_valid=1 together. Required: the first cycle pops 0xBFC00000 with no push (count=3); afterwards push and pop both occur and count stays constant.
- Stream 10 pairs with out_ready=1 and continuous in_valid. Required: decode sees all 10 PCs in order through the pointer wrap, each one cycle after its push.
- At count=3, assert flush with in_valid=1 and out_ready=1. Required: no pop during the flush cycle and the incoming pair is dropped; next cycle count=0, out_valid=0, fetch_stall=0, in_ready=1.
- At count=2, assert rst for one cycle. Required: all outputs take their reset values after the edge, and a subsequent push behaves as in the first scenario.
